note_search: RTL and testbench
==============================

Name: note_search

Overview:
- Upstream address generator and consumer for the key-filtered note LUT.
- Accepts a detected pitch and binary-searches the selected key's ascending f0 table for the nearest in-key note.
- Emits the index and full LUT word (f0 and 1/f0) to the scale-factor datapath.
- Drives the LUT's note_addr and key_select and samples its note_inv_note output.

Parameters:
NOTE_DATA_WIDTH, 38, LUT word width; the upper NOTE_DATA_WIDTH/2 bits are f0.
NOTE_ADDR_WIDTH, 6, LUT address width; the table holds 2^NOTE_ADDR_WIDTH entries.
FREQ_WIDTH, 19, pitch/f0 width; must equal NOTE_DATA_WIDTH/2. Unsigned, same fixed-point format as the LUT f0 field.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
key_select_in  in  2  requested key; sampled on accept
pitch_in  in  FREQ_WIDTH  detected pitch
in_valid  in  1  pitch_in valid
in_ready  out  1  block idle, can accept
key_select  out  2  to LUT; registered copy of the latched key
note_addr  out  NOTE_ADDR_WIDTH  to LUT; registered
note_inv_note  in  NOTE_DATA_WIDTH  LUT data; valid one cycle after note_addr is presented
note_idx_out  out  NOTE_ADDR_WIDTH  nearest note index
note_word_out  out  NOTE_DATA_WIDTH  LUT word at note_idx_out
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result

Behaviour:
- Reset values: in_ready=1, out_valid=0, note_addr=0, key_select=0, note_idx_out=0, note_word_out=0. FSM goes to IDLE.
- Reset mid-search or mid-hold aborts the operation. No partial result is emitted.
- LUT timing: note_addr is registered. The LUT captures it at the end of cycle c, and note_inv_note is sampled in cycle c+1. Each read therefore costs 2 cycles: state RD_ADDR, then RD_DATA.
- f0 field = note_inv_note[NOTE_DATA_WIDTH-1 -: FREQ_WIDTH]. Table entries are ascending and strictly increasing.
- States:
  - IDLE: in_ready=1. On in_valid, latch pitch and key_select_in (key_select updates next cycle), load note_addr=0, go to READ0.
  - READ0: read index 0 and store f_lo=f0[0], idx=0.
  - PROBE (b = NOTE_ADDR_WIDTH-1 down to 0, one read each):
    - probe address = idx | (1<<b).
    - If f0[probe] <= pitch: idx=probe, f_lo=f0[probe].
  - NEIGHBOR: read min(idx+1, 2^NOTE_ADDR_WIDTH-1), giving f_hi.
  - Choose the result:
    - pitch < f_lo (below table): choose idx (=0).
    - idx = max: choose idx.
    - Otherwise choose idx+1 iff (f_hi-pitch) < (pitch-f_lo). A tie selects the lower index.
    - Differences use unsigned FREQ_WIDTH+1-bit arithmetic, with no overflow.
  - FINAL: read the chosen index and register note_idx_out and note_word_out.
  - HOLD: out_valid=1. Outputs stay stable until out_ready=1, then the FSM goes to IDLE with out_valid=0 next cycle.
  - in_ready is low in every state except IDLE. There is no accept on the cycle out_valid drops.
- Fixed latency: total reads = NOTE_ADDR_WIDTH+3 = 9. With accept in cycle N, out_valid rises in cycle N+19. The NEIGHBOR read is always performed, even at max index.
- key_select_in changes after accept are ignored. key_select holds the latched value until the next accept, so the LUT output mux is stable for the whole search.
- in_valid is ignored while busy. pitch_in is not required to be held after accept.
- Pitch equal to an entry selects that entry (the <= compare).
- Pitch at or above the last entry selects the max index.

Test Plan:
- Behavioural LUT with 1-cycle latency, f0[i]=1000*(i+1), key 0. Apply pitch=5400 -> out_valid at N+19, note_idx_out=4, f0 field=5000.
- pitch=5500 (tie) -> idx 4. pitch=5501 -> idx 5. pitch=6000 (exact) -> idx 5.
- pitch=100 -> idx 0. pitch=500000 -> idx 63, word=f0 64000. Both at fixed latency N+19.
- Key isolation: key 1 table f0[i]=1500*(i+1). Accept pitch=3100 with key 1, toggle key_select_in every cycle afterwards -> key_select stays 1, idx 1 (3000).
- Backpressure: out_ready=0 for 10 cycles -> outputs stable and in_ready=0 with in_valid held high. Then out_ready=1 -> in_ready=1 next cycle, and back-to-back search accepted.
- Reset asserted at N+7 -> next cycle in_ready=1, out_valid=0, note_addr=0. A new request completes with the correct idx at the new N+19.

Source files
------------

// File: rtl/note_search.sv
// note_search: binary search of a key-filtered, ascending f0 LUT
// for the note nearest to a detected pitch; drives and reads the LUT.
module note_search #(
    parameter int NOTE_DATA_WIDTH = 38,
    parameter int NOTE_ADDR_WIDTH = 6,
    parameter int FREQ_WIDTH      = 19
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [1:0]                 key_select_in,
    input  logic [FREQ_WIDTH-1:0]      pitch_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [1:0]                 key_select,
    output logic [NOTE_ADDR_WIDTH-1:0] note_addr,
    input  logic [NOTE_DATA_WIDTH-1:0] note_inv_note,
    output logic [NOTE_ADDR_WIDTH-1:0] note_idx_out,
    output logic [NOTE_DATA_WIDTH-1:0] note_word_out,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int AW = NOTE_ADDR_WIDTH;
    localparam int FW = FREQ_WIDTH;
    localparam int DW = NOTE_DATA_WIDTH;
    localparam int BW = $clog2(AW) + 1;

    localparam logic [AW-1:0] MAX_IDX  = '1;
    localparam logic [BW-1:0] TOP_BIT  = BW'(AW - 1);
    localparam logic [AW-1:0] ONE_ADDR = AW'(1);

    // Each LUT read is an address cycle (_A) followed by a data cycle (_D)
    typedef enum logic [3:0] {
        S_IDLE,
        S_R0_A,
        S_R0_D,
        S_PR_A,
        S_PR_D,
        S_NB_A,
        S_NB_D,
        S_FN_A,
        S_FN_D,
        S_HOLD
    } state_e;

    state_e          state_q, state_d;
    logic [FW-1:0]   pitch_q, pitch_d;
    logic [1:0]      key_q, key_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [FW-1:0]   f_lo_q, f_lo_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [AW-1:0]   idx_out_q, idx_out_d;
    logic [DW-1:0]   word_out_q, word_out_d;

    // Scratch signals for the data-cycle decisions
    logic [FW-1:0]   f0_rd;
    logic [AW-1:0]   idx_new;
    logic [FW:0]     d_hi;
    logic [FW:0]     d_lo;
    logic            below;
    logic            at_max;
    logic            choose_up;

    assign f0_rd = note_inv_note[DW-1 -: FW];

    // Neighbour differences; only meaningful when f_lo <= pitch < f_hi
    assign d_hi   = {1'b0, f0_rd} - {1'b0, pitch_q};
    assign d_lo   = {1'b0, pitch_q} - {1'b0, f_lo_q};
    assign below  = pitch_q < f_lo_q;
    assign at_max = idx_q == MAX_IDX;
    assign choose_up = !below && !at_max && (d_hi < d_lo);

    // Next-state and datapath updates for the search sequence
    always_comb begin
        state_d    = state_q;
        pitch_d    = pitch_q;
        key_d      = key_q;
        addr_d     = addr_q;
        idx_d      = idx_q;
        f_lo_d     = f_lo_q;
        bit_d      = bit_q;
        idx_out_d  = idx_out_q;
        word_out_d = word_out_q;
        idx_new    = idx_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    pitch_d = pitch_in;
                    key_d   = key_select_in;
                    addr_d  = '0;
                    state_d = S_R0_A;
                end
            end
            S_R0_A: state_d = S_R0_D;
            S_R0_D: begin
                idx_d   = '0;
                f_lo_d  = f0_rd;
                bit_d   = TOP_BIT;
                addr_d  = ONE_ADDR << TOP_BIT;
                state_d = S_PR_A;
            end
            S_PR_A: state_d = S_PR_D;
            S_PR_D: begin
                if (f0_rd <= pitch_q) begin
                    idx_new = addr_q;
                    f_lo_d  = f0_rd;
                end
                idx_d = idx_new;
                if (bit_q == '0) begin
                    addr_d  = (idx_new == MAX_IDX) ? MAX_IDX
                                                   : idx_new + 1'b1;
                    state_d = S_NB_A;
                end else begin
                    bit_d   = bit_q - 1'b1;
                    addr_d  = idx_new | (ONE_ADDR << (bit_q - 1'b1));
                    state_d = S_PR_A;
                end
            end
            S_NB_A: state_d = S_NB_D;
            S_NB_D: begin
                addr_d  = choose_up ? idx_q + 1'b1 : idx_q;
                state_d = S_FN_A;
            end
            S_FN_A: state_d = S_FN_D;
            S_FN_D: begin
                idx_out_d  = addr_q;
                word_out_d = note_inv_note;
                state_d    = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pitch_q    <= '0;
            key_q      <= '0;
            addr_q     <= '0;
            idx_q      <= '0;
            f_lo_q     <= '0;
            bit_q      <= '0;
            idx_out_q  <= '0;
            word_out_q <= '0;
        end else begin
            state_q    <= state_d;
            pitch_q    <= pitch_d;
            key_q      <= key_d;
            addr_q     <= addr_d;
            idx_q      <= idx_d;
            f_lo_q     <= f_lo_d;
            bit_q      <= bit_d;
            idx_out_q  <= idx_out_d;
            word_out_q <= word_out_d;
        end
    end

    assign in_ready      = state_q == S_IDLE;
    assign out_valid     = state_q == S_HOLD;
    assign key_select    = key_q;
    assign note_addr     = addr_q;
    assign note_idx_out  = idx_out_q;
    assign note_word_out = word_out_q;

endmodule

// File: tb/tb_note_search.sv
// tb_note_search: randomized and directed checks of note_search
// against a brute-force nearest-note model over a behavioural LUT.
module tb_note_search;

    localparam int DW = 38;
    localparam int AW = 6;
    localparam int FW = 19;
    localparam int N  = 64;

    logic          clock = 1'b0;
    logic          reset;
    logic [1:0]    key_select_in;
    logic [FW-1:0] pitch_in;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    key_select;
    logic [AW-1:0] note_addr;
    logic [DW-1:0] note_inv_note;
    logic [AW-1:0] note_idx_out;
    logic [DW-1:0] note_word_out;
    logic          out_valid;
    logic          out_ready;

    note_search #(
        .NOTE_DATA_WIDTH(DW),
        .NOTE_ADDR_WIDTH(AW),
        .FREQ_WIDTH(FW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .key_select_in(key_select_in),
        .pitch_in(pitch_in),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .key_select(key_select),
        .note_addr(note_addr),
        .note_inv_note(note_inv_note),
        .note_idx_out(note_idx_out),
        .note_word_out(note_word_out),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clock = ~clock;

    // Behavioural LUT: 4 key tables, one-cycle registered read
    logic [DW-1:0] lut [4][N];
    logic [DW-1:0] lut_q = '0;

    always @(posedge clock) lut_q <= lut[key_select][note_addr];
    assign note_inv_note = lut_q;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int f0_of(input int k, input int i);
        logic [DW-1:0] w;
        w = lut[k][i];
        return int'(w[DW-1 -: FW]);
    endfunction

    // Nearest entry by exhaustive scan; ties keep the lower index
    function automatic int ref_idx(input int k, input int p);
        int best;
        int bd;
        int d;
        best = 0;
        bd = (f0_of(k, 0) > p) ? f0_of(k, 0) - p : p - f0_of(k, 0);
        for (int i = 1; i < N; i++) begin
            d = (f0_of(k, i) > p) ? f0_of(k, i) - p : p - f0_of(k, i);
            if (d < bd) begin
                best = i;
                bd = d;
            end
        end
        return best;
    endfunction

    // One request starting at a negedge while the DUT is idle;
    // returns at a negedge after the result has been released.
    task automatic run_req(input int p, input int k, input int exp_idx,
                           input int hold, input bit keep_valid,
                           input int next_p);
        int lat;
        check("in_ready_idle", in_ready, 1);
        pitch_in = FW'(p);
        key_select_in = 2'(k);
        in_valid = 1'b1;
        out_ready = (hold == 0);
        @(posedge clock);
        lat = 1;
        @(negedge clock);
        check("in_ready_busy", in_ready, 0);
        while (!out_valid && lat < 40) begin
            in_valid = 1'($urandom);
            pitch_in = FW'($urandom);
            key_select_in = 2'($urandom);
            @(negedge clock);
            lat++;
            if (!out_valid && key_select != 2'(k))
                check("key_stable", key_select, k);
        end
        in_valid = keep_valid;
        pitch_in = FW'(next_p);
        key_select_in = 2'b00;
        check("latency", lat, 19);
        check("out_valid", out_valid, 1);
        check("idx", note_idx_out, exp_idx);
        check("word", note_word_out, lut[k][exp_idx]);
        check("key_select", key_select, k);
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_idx", note_idx_out, exp_idx);
            check("hold_word", note_word_out, lut[k][exp_idx]);
        end
        out_ready = 1'b1;
        @(negedge clock);
        check("release_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
    endtask

    int p;
    int k;
    int sel;
    int f;
    bit leak;

    initial begin
        for (int i = 0; i < N; i++) begin
            lut[0][i] = {FW'(1000 * (i + 1)), FW'(i * 7919 + 3)};
            lut[1][i] = {FW'(1500 * (i + 1)), FW'(i * 4111 + 17)};
            lut[3][i] = {FW'(7000 * (i + 1)), FW'(i * 2713 + 5)};
        end
        f = $urandom_range(1, 3000);
        for (int i = 0; i < N; i++) begin
            lut[2][i] = {FW'(f), FW'($urandom)};
            f += $urandom_range(1, 4000);
        end

        reset = 1'b1;
        in_valid = 1'b0;
        pitch_in = '0;
        key_select_in = 2'b00;
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_note_addr", note_addr, 0);
        check("rst_key_select", key_select, 0);
        check("rst_idx", note_idx_out, 0);
        check("rst_word", note_word_out, 0);

        run_req(5400, 0, 4, 0, 0, 0);
        check("f0_5400", note_word_out[DW-1 -: FW], 5000);
        run_req(5500, 0, 4, 0, 0, 0);
        run_req(5501, 0, 5, 0, 0, 0);
        run_req(6000, 0, 5, 0, 0, 0);
        run_req(100, 0, 0, 0, 0, 0);
        run_req(500000, 0, 63, 0, 0, 0);
        check("f0_max", note_word_out[DW-1 -: FW], 64000);
        run_req(3100, 1, 1, 0, 0, 0);

        run_req(7200, 0, 6, 10, 1, 12345);
        run_req(12345, 0, 11, 0, 0, 0);

        check("pre_reset_idle", in_ready, 1);
        pitch_in = FW'(20000);
        key_select_in = 2'd3;
        in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        repeat (6) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_note_addr", note_addr, 0);
        check("mid_rst_key", key_select, 0);
        leak = 1'b0;
        repeat (25) begin
            @(negedge clock);
            if (out_valid) leak = 1'b1;
        end
        check("no_partial", leak, 0);
        run_req(20000, 3, 2, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, 3);
            sel = $urandom_range(0, 2);
            case (sel)
                0: p = f0_of(k, $urandom_range(0, N - 1));
                1: begin
                    f = $urandom_range(0, N - 2);
                    p = (f0_of(k, f) + f0_of(k, f + 1)) / 2
                        + $urandom_range(0, 2) - 1;
                end
                default: p = $urandom_range(0, f0_of(k, N - 1) + 2000);
            endcase
            run_req(p, k, ref_idx(k, p), $urandom_range(0, 3), 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
